// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the two-lane ALU arbiter.
//   NUM_LANES   : number of requesting lanes sharing the ALU
//   DATA_W      : operand / result width
//   CNT_W       : width of the per-lane grant counters
//   alu_op_e    : 4-bit ALU opcode encoding
//   sat_inc     : saturating increment used by the grant counters
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int NUM_LANES = 2;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] next_value;
        if (value == {CNT_W{1'b1}}) begin
            next_value = value;
        end else begin
            next_value = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return next_value;
    endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU.
// Ports:
//   src_a       in  32  operand A
//   src_b       in  32  operand B (shift amount taken from src_b[4:0])
//   alu_control in   4  opcode (alu_pkg::alu_op_e encoding)
//   result      out 32  operation result; undefined opcodes give 0
//   zero        out  1  result == 0
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [3:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic [4:0] shamt_s;

    assign shamt_s = src_b[4:0];

    // Opcode decode and datapath; all arithmetic wraps modulo 2^32.
    always_comb begin
        result = {DATA_W{1'b0}};
        case (alu_control)
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SLL:  result = src_a << shamt_s;
            ALU_SRL:  result = src_a >> shamt_s;
            ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt_s);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            ALU_LUI:  result = src_b;
            default:  result = {DATA_W{1'b0}};
        endcase
    end

    assign zero = (result == {DATA_W{1'b0}});

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two request lanes. At most one request
// is accepted per cycle (round-robin on a 1-bit priority pointer); the result
// is latched into the winning lane's one-entry slot and presented one cycle
// later. A slot draining in the same cycle can accept a new request, so each
// lane can sustain one result per cycle when it is the only requester.
// Ports:
//   clk            in   1          clock, rising edge
//   rst_n          in   1          asynchronous active-low reset
//   ReqValid       in   2          per-lane request valid
//   ReqReady       out  2          per-lane request accept (one-hot or zero)
//   ReqSrcA        in   2x32       per-lane operand A
//   ReqSrcB        in   2x32       per-lane operand B
//   ReqALUControl  in   2x4        per-lane opcode
//   ReqTag         in   2xTAG_W    per-lane tag
//   RespValid      out  2          per-lane result valid (slot FULL)
//   RespReady      in   2          per-lane result consume
//   RespResult     out  2x32       per-lane result
//   RespZero       out  2          per-lane zero flag
//   RespTag        out  2xTAG_W    per-lane returned tag
//   GrantCount     out  2x16       per-lane saturating accept counter
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_LANES-1:0]                ReqValid,
    output logic [NUM_LANES-1:0]                ReqReady,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]    ReqSrcA,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]    ReqSrcB,
    input  logic [NUM_LANES-1:0][3:0]           ReqALUControl,
    input  logic [NUM_LANES-1:0][TAG_W-1:0]     ReqTag,
    output logic [NUM_LANES-1:0]                RespValid,
    input  logic [NUM_LANES-1:0]                RespReady,
    output logic [NUM_LANES-1:0][DATA_W-1:0]    RespResult,
    output logic [NUM_LANES-1:0]                RespZero,
    output logic [NUM_LANES-1:0][TAG_W-1:0]     RespTag,
    output logic [NUM_LANES-1:0][CNT_W-1:0]     GrantCount
);

    // Slot state: 1 = FULL, 0 = EMPTY.
    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    logic [NUM_LANES-1:0]               slot_r;
    logic [NUM_LANES-1:0][DATA_W-1:0]   result_r;
    logic [NUM_LANES-1:0]               zero_r;
    logic [NUM_LANES-1:0][TAG_W-1:0]    tag_r;
    logic [NUM_LANES-1:0][CNT_W-1:0]    count_r;
    logic                               prio_r;

    logic [NUM_LANES-1:0]               drain_s;
    logic [NUM_LANES-1:0]               elig_s;
    logic                               grant_valid_s;
    logic                               grant_lane_s;
    logic [NUM_LANES-1:0]               ready_s;
    logic [DATA_W-1:0]                  alu_a_s;
    logic [DATA_W-1:0]                  alu_b_s;
    logic [3:0]                         alu_op_s;
    logic [DATA_W-1:0]                  alu_result_s;
    logic                               alu_zero_s;

    assign drain_s = slot_r & RespReady;
    // A slot that empties on this edge may be refilled on the same edge.
    assign elig_s  = ReqValid & (~slot_r | drain_s);

    // Round-robin pick; operands never influence the decision.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_lane_s  = 1'b0;
        if (elig_s == 2'b11) begin
            grant_valid_s = 1'b1;
            grant_lane_s  = prio_r;
        end else if (elig_s[0]) begin
            grant_valid_s = 1'b1;
            grant_lane_s  = 1'b0;
        end else if (elig_s[1]) begin
            grant_valid_s = 1'b1;
            grant_lane_s  = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_lane_s  = 1'b0;
        end
    end

    // One-hot accept; forced low while reset is held so nothing is offered.
    always_comb begin
        ready_s = {NUM_LANES{1'b0}};
        if (grant_valid_s && rst_n) begin
            ready_s[grant_lane_s] = 1'b1;
        end else begin
            ready_s = {NUM_LANES{1'b0}};
        end
    end

    assign ReqReady = ready_s;
    assign alu_a_s  = ReqSrcA[grant_lane_s];
    assign alu_b_s  = ReqSrcB[grant_lane_s];
    assign alu_op_s = ReqALUControl[grant_lane_s];

    alu u_alu (
        .src_a       (alu_a_s),
        .src_b       (alu_b_s),
        .alu_control (alu_op_s),
        .result      (alu_result_s),
        .zero        (alu_zero_s)
    );

    // Priority pointer: moves to the other lane after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (|ready_s) begin
            prio_r <= ~grant_lane_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Per-lane slots and grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r   <= {NUM_LANES{SLOT_EMPTY}};
            result_r <= '0;
            zero_r   <= {NUM_LANES{1'b0}};
            tag_r    <= '0;
            count_r  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (ready_s[i]) begin
                    slot_r[i]   <= SLOT_FULL;
                    result_r[i] <= alu_result_s;
                    zero_r[i]   <= alu_zero_s;
                    tag_r[i]    <= ReqTag[i];
                    count_r[i]  <= sat_inc(count_r[i]);
                end else if (drain_s[i]) begin
                    slot_r[i]   <= SLOT_EMPTY;
                end else begin
                    slot_r[i]   <= slot_r[i];
                end
            end
        end
    end

    assign RespValid  = slot_r;
    assign RespResult = result_r;
    assign RespZero   = zero_r;
    assign RespTag    = tag_r;
    assign GrantCount = count_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Randomized and directed stimulus against a behavioural reference model.
// Per cycle (posedge at T): inputs driven at T+2, monitor checks responses and
// pops drained entries at T+4, stimulus checks ReqReady and pushes expected
// results at T+6.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int TAG_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic [1:0]             ReqValid;
    logic [1:0]             ReqReady;
    logic [1:0][31:0]       ReqSrcA;
    logic [1:0][31:0]       ReqSrcB;
    logic [1:0][3:0]        ReqALUControl;
    logic [1:0][TAG_W-1:0]  ReqTag;
    logic [1:0]             RespValid;
    logic [1:0]             RespReady;
    logic [1:0][31:0]       RespResult;
    logic [1:0]             RespZero;
    logic [1:0][TAG_W-1:0]  RespTag;
    logic [1:0][15:0]       GrantCount;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ReqValid      (ReqValid),
        .ReqReady      (ReqReady),
        .ReqSrcA       (ReqSrcA),
        .ReqSrcB       (ReqSrcB),
        .ReqALUControl (ReqALUControl),
        .ReqTag        (ReqTag),
        .RespValid     (RespValid),
        .RespReady     (RespReady),
        .RespResult    (RespResult),
        .RespZero      (RespZero),
        .RespTag       (RespTag),
        .GrantCount    (GrantCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic             z;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   mprio;
    int   mcnt[2];
    int   n_vec;
    int   n_err;

    // Reference ALU written from the opcode table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b & 32'd31;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd15:   return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_lane(input int l);
        exp_t e;
        bit   have;
        have = (l == 0) ? (q0.size() != 0) : (q1.size() != 0);
        check($sformatf("resp_valid[%0d]", l), 32'(RespValid[l]), 32'(have));
        if (have) begin
            e = (l == 0) ? q0[0] : q1[0];
            check($sformatf("resp_result[%0d]", l), RespResult[l], e.res);
            check($sformatf("resp_zero[%0d]", l), 32'(RespZero[l]), 32'(e.z));
            check($sformatf("resp_tag[%0d]", l), 32'(RespTag[l]), 32'(e.tag));
            if (RespValid[l] && RespReady[l]) begin
                if (l == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
        check($sformatf("grant_count[%0d]", l), 32'(GrantCount[l]), 32'(mcnt[l]));
    endtask

    // Monitor: compares presented responses with the scoreboard each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #4;
            check_lane(0);
            check_lane(1);
        end
    end

    task automatic step(input logic rst_v, input logic [1:0] rv, input logic [1:0] rr,
                        input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] t0,
                        input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1);
        logic [1:0] exp_rdy;
        bit         e0;
        bit         e1;
        int         g;
        exp_t       e;
        @(posedge clk);
        #2;
        rst_n            = rst_v;
        ReqValid         = rv;
        RespReady        = rr;
        ReqALUControl[0] = op0;
        ReqSrcA[0]       = a0;
        ReqSrcB[0]       = b0;
        ReqTag[0]        = t0;
        ReqALUControl[1] = op1;
        ReqSrcA[1]       = a1;
        ReqSrcB[1]       = b1;
        ReqTag[1]        = t1;
        if (!rst_v) begin
            q0.delete();
            q1.delete();
            mprio  = 0;
            mcnt[0] = 0;
            mcnt[1] = 0;
            #1;
            check("rst_resp_valid", 32'(RespValid), 32'd0);
            check("rst_grant_count0", 32'(GrantCount[0]), 32'd0);
            check("rst_grant_count1", 32'(GrantCount[1]), 32'd0);
            #3;
        end else begin
            #4;
        end
        // Slot counts as free when the model queue is empty (drains already popped).
        e0 = rst_v && rv[0] && (q0.size() == 0);
        e1 = rst_v && rv[1] && (q1.size() == 0);
        if (e0 && e1) g = mprio;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        else          g = -1;
        exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        check("req_ready", 32'(ReqReady), 32'(exp_rdy));
        if (g == 0) begin
            e.res = ref_alu(op0, a0, b0);
            e.z   = (e.res == 32'd0);
            e.tag = t0;
            q0.push_back(e);
        end else if (g == 1) begin
            e.res = ref_alu(op1, a1, b1);
            e.z   = (e.res == 32'd0);
            e.tag = t1;
            q1.push_back(e);
        end
        if (g >= 0) begin
            if (mcnt[g] < 65535) mcnt[g]++;
            mprio = 1 - g;
        end
    endtask

    task automatic rnd_step(input logic [1:0] rv_mask);
        logic [31:0] b0;
        logic [31:0] b1;
        b0 = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
        b1 = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
        step(1'b1, 2'($urandom) & rv_mask, 2'($urandom),
             4'($urandom), $urandom, b0, 4'($urandom),
             4'($urandom), $urandom, b1, 4'($urandom));
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        mprio         = 0;
        mcnt[0]       = 0;
        mcnt[1]       = 0;
        rst_n         = 1'b0;
        ReqValid      = 2'b00;
        RespReady     = 2'b00;
        ReqSrcA       = '0;
        ReqSrcB       = '0;
        ReqALUControl = '0;
        ReqTag        = '0;

        // Held in reset with requests pending: nothing accepted.
        step(1'b0, 2'b11, 2'b11, 4'd0, 32'd1, 32'd2, 4'd1, 4'd0, 32'd3, 32'd4, 4'd2);
        step(1'b0, 2'b11, 2'b11, 4'd0, 32'd1, 32'd2, 4'd1, 4'd0, 32'd3, 32'd4, 4'd2);

        // Lane 0 ADD 5+7 tag 3, accepted on the first edge after release.
        step(1'b1, 2'b01, 2'b11, 4'd0, 32'd5, 32'd7, 4'd3, 4'd0, 32'd0, 32'd0, 4'd0);
        // SUB 1-1, undefined opcode, SRA 0x80000000 by 4.
        step(1'b1, 2'b01, 2'b11, 4'd1, 32'd1, 32'd1, 4'd4, 4'd0, 32'd0, 32'd0, 4'd0);
        step(1'b1, 2'b01, 2'b11, 4'd10, 32'd9, 32'd3, 4'd5, 4'd0, 32'd0, 32'd0, 4'd0);
        step(1'b1, 2'b01, 2'b11, 4'd7, 32'h8000_0000, 32'd4, 4'd6, 4'd0, 32'd0, 32'd0, 4'd0);
        step(1'b1, 2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0);

        // Both lanes saturating the ALU: grants alternate.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'b11, 2'b11, 4'd0, $urandom, $urandom, 4'($urandom),
                 4'd1, $urandom, $urandom, 4'($urandom));
        end
        step(1'b1, 2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0);

        // Lane 0 held FULL, prio back at 0: lane 1 still wins, lane 0 held stable.
        step(1'b1, 2'b01, 2'b00, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd7, 4'd0, 32'd0, 32'd0, 4'd0);
        step(1'b1, 2'b10, 2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 4'd3, 32'h1, 32'h2, 4'd8);
        step(1'b1, 2'b11, 2'b10, 4'd0, 32'd9, 32'd9, 4'd9, 4'd4, 32'hAAAA, 32'h5555, 4'd10);
        step(1'b1, 2'b11, 2'b10, 4'd0, 32'd9, 32'd9, 4'd9, 4'd8, 32'hFFFF_FFFF, 32'd1, 4'd11);
        step(1'b1, 2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) rnd_step(2'b11);

        // Fill both slots, then reset mid-operation.
        step(1'b1, 2'b11, 2'b00, 4'd0, 32'd1, 32'd1, 4'd1, 4'd0, 32'd2, 32'd2, 4'd2);
        step(1'b1, 2'b11, 2'b00, 4'd0, 32'd1, 32'd1, 4'd1, 4'd0, 32'd2, 32'd2, 4'd2);
        step(1'b1, 2'b11, 2'b00, 4'd0, 32'd1, 32'd1, 4'd1, 4'd0, 32'd2, 32'd2, 4'd2);
        step(1'b0, 2'b11, 2'b00, 4'd0, 32'd1, 32'd1, 4'd1, 4'd0, 32'd2, 32'd2, 4'd2);
        step(1'b0, 2'b00, 2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd0, 32'd2, 32'd2, 4'd2);
        // Release with both lanes requesting: prio 0 means lane 0 first.
        step(1'b1, 2'b11, 2'b11, 4'd9, 32'd1, 32'd2, 4'd12, 4'd8, 32'd3, 32'd4, 4'd13);
        for (int i = 0; i < 200; i++) rnd_step(2'b11);

        // Lane 1 only, one request per cycle, past counter saturation.
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 2'b10, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0,
                 4'($urandom_range(9, 0)), $urandom, $urandom, 4'($urandom));
        end
        step(1'b1, 2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0);
        check("grant_count1_saturated", 32'(GrantCount[1]), 32'h0000_FFFF);
        step(1'b1, 2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
